alu_nibble_sequencer: RTL and testbench
=======================================

// Module: alu_nibble_sequencer
// PURPOSE
//   Multi-cycle controller that drives the 4-bit combinational ALU (pins S2..S0, Cin, A, B -> G, Cout).
//   Accepts one WIDTH-bit op via valid/ready and runs it through the ALU one nibble per cycle, LSB nibble first.
//   Chains carry between nibbles, registers the result and flags, and returns them via valid/ready.
//   Sits between the register file / decode stage and the ALU instance.
// PARAMETERS
//   WIDTH  16  operand/result width; multiple of 4, >= 4. NIB = WIDTH/4 ALU passes per op.
// PORTS
//   clk        in   1      single clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   req_valid  in   1      request present
//   req_ready  out  1      sequencer can accept (IDLE)
//   req_op     in   3      {S2,S1,S0} ALU opcode
//   req_cin    in   1      carry-in to nibble 0
//   req_a      in   WIDTH  operand A
//   req_b      in   WIDTH  operand B
//   alu_s2     out  1      to ALU S2
//   alu_s1     out  1      to ALU S1
//   alu_s0     out  1      to ALU S0
//   alu_cin    out  1      to ALU Cin
//   alu_a      out  4      to ALU A
//   alu_b      out  4      to ALU B
//   alu_g      in   4      from ALU G
//   alu_cout   in   1      from ALU Cout
//   rsp_valid  out  1      result valid
//   rsp_ready  in   1      consumer accepts result
//   rsp_g      out  WIDTH  result
//   rsp_cout   out  1      final carry (arith); 0 for logic ops
//   rsp_zero   out  1      rsp_g == 0
//   rsp_neg    out  1      rsp_g[WIDTH-1]
// BEHAVIOUR
//   Opcodes, per nibble:
//     Arith (S2=0): 000 A+Cin; 001 A+B+Cin; 010 A+~B+Cin; 011 A+4'hF+Cin.
//     Logic (S2=1): 100 AND; 101 OR; 110 XOR; 111 ~A.
//   FSM states: IDLE, RUN, DONE. Reset -> IDLE.
//   Reset values: all registers 0; rsp_valid=0; all alu_* outputs=0. req_ready=1 once reset releases.
//   req_ready = (state==IDLE). It is combinational; no accept in RUN or DONE.
//   IDLE: on req_valid&&req_ready, latch op/cin/a/b, idx<=0, state->RUN.
//   RUN: idx selects nibble. alu_a=a_q[4*idx+:4]; alu_b=b_q[4*idx+:4]; alu_s*=op_q.
//     alu_cin = (idx==0) ? cin_q : carry_q. Logic ops still drive the chained carry; the ALU ignores it.
//     Each edge: res[4*idx+:4]<=alu_g; carry_q<=alu_cout; idx++.
//     At idx==NIB-1: state->DONE.
//   Latency: rsp_valid rises NIB cycles after the accept edge (4 for WIDTH=16).
//   DONE: rsp_valid=1. rsp_* are stable until rsp_valid&&rsp_ready; then state->IDLE.
//     Next accept is possible one cycle later, earliest.
//   alu_* outputs are 0 in IDLE and DONE.
//   rsp_cout = op_q[2] ? 0 : carry_q.
//   rsp_zero/rsp_neg are derived from the registered result and are valid only with rsp_valid.
//   rsp_ready high while not DONE: ignored.
//   rst asserted mid-RUN/DONE: op is aborted, no response, all outputs return to reset values immediately.
//   WIDTH=4: RUN lasts one cycle.
// CONFIGURATION
//   ALU_SEQ_OVF_EN defined: adds output port rsp_ovf (1 bit), signed overflow for arith ops.
//     y_msb = {0, b_msb, ~b_msb, 1} for op 000/001/010/011.
//     rsp_ovf = !op[2] && (a_msb==y_msb) && (g_msb!=a_msb). Reset 0; 0 for logic ops.
//   Undefined: port rsp_ovf absent; no overflow logic.
// TESTING (WIDTH=16, sequencer wired to the 4-bit ALU)
//   op001 cin0 A=1234 B=0FFF -> rsp_g=2233, cout0, zero0; rsp_valid exactly 4 cycles after accept.
//   op010 cin1 A=0005 B=0007 -> rsp_g=FFFE, cout0, neg1; ovf0 with ALU_SEQ_OVF_EN.
//   op001 cin0 A=FFFF B=0001 -> rsp_g=0000, cout1, zero1.
//   op001 A=7FFF B=0001 -> 8000, neg1, ovf1 (macro on).
//   Logic ops, cout 0 in both cases:
//     op110 A=F0F0 B=FF00 -> 0FF0.
//     op111 A=00FF -> FF00.
//   Backpressure, then reset mid-op:
//     Hold rsp_ready=0 for 5 cycles: rsp_g stable, req_ready=0, second req not taken.
//     Then rst during RUN: rsp_valid never rises, req_ready=1 after release.

Source files
------------

// File: rtl/alu_nibble_sequencer.sv
// rtl/alu_nibble_sequencer.sv - nibble-serial controller for a 4-bit combinational ALU
// Optional feature macro: ALU_SEQ_OVF_EN (adds rsp_ovf signed-overflow output)
module alu_nibble_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic             req_cin,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic             alu_s2,
   output logic             alu_s1,
   output logic             alu_s0,
   output logic             alu_cin,
   output logic [3:0]       alu_a,
   output logic [3:0]       alu_b,
   input  logic [3:0]       alu_g,
   input  logic             alu_cout,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_g,
   output logic             rsp_cout,
   output logic             rsp_zero,
`ifdef ALU_SEQ_OVF_EN
   output logic             rsp_ovf,
`endif
   output logic             rsp_neg
);

   localparam int NIB  = WIDTH / 4;
   localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [2:0]       r_op;
   logic             r_cin;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic             r_carry;
   logic [IDXW-1:0]  r_idx;
   logic [IDXW+1:0]  w_bit_base;
   logic             w_accept;

   assign w_bit_base = {r_idx, 2'b00};
   assign w_accept   = req_valid && (r_state == S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      alu_s2      = 1'b0;
      alu_s1      = 1'b0;
      alu_s0      = 1'b0;
      alu_cin     = 1'b0;
      alu_a       = 4'h0;
      alu_b       = 4'h0;
      case (r_state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            {alu_s2, alu_s1, alu_s0} = r_op;
            // carry into nibble 0 comes from the request; later nibbles chain
            alu_cin = (r_idx == '0) ? r_cin : r_carry;
            alu_a   = r_a[w_bit_base +: 4];
            alu_b   = r_b[w_bit_base +: 4];
            if (r_idx == LAST_IDX) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op    <= 3'b000;
         r_cin   <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_carry <= 1'b0;
         r_idx   <= '0;
      end else begin
         if (w_accept) begin
            r_op  <= req_op;
            r_cin <= req_cin;
            r_a   <= req_a;
            r_b   <= req_b;
            r_idx <= '0;
         end else if (r_state == S_RUN) begin
            r_res[w_bit_base +: 4] <= alu_g;
            r_carry                <= alu_cout;
            r_idx                  <= r_idx + 1'b1;
         end
      end
   end

   assign rsp_g    = r_res;
   assign rsp_cout = r_op[2] ? 1'b0 : r_carry;
   // zero is qualified so an all-zero reset result does not read as a zero flag
   assign rsp_zero = (r_state == S_DONE) && (r_res == '0);
   assign rsp_neg  = r_res[WIDTH-1];

`ifdef ALU_SEQ_OVF_EN
   logic w_y_msb;

   always_comb begin
      w_y_msb = 1'b0;
      case (r_op[1:0])
         2'b00:   w_y_msb = 1'b0;
         2'b01:   w_y_msb = r_b[WIDTH-1];
         2'b10:   w_y_msb = ~r_b[WIDTH-1];
         default: w_y_msb = 1'b1;
      endcase
   end

   assign rsp_ovf = !r_op[2] && (r_a[WIDTH-1] == w_y_msb) && (r_res[WIDTH-1] != r_a[WIDTH-1]);
`endif

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// tb/tb_alu_nibble_sequencer.sv - scoreboard bench for alu_nibble_sequencer with a 4-bit ALU model
module tb_alu_nibble_sequencer;

   localparam int WIDTH = 16;

   logic             clk;
   logic             rst;
   logic             req_valid;
   logic             req_ready;
   logic [2:0]       req_op;
   logic             req_cin;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic             alu_s2;
   logic             alu_s1;
   logic             alu_s0;
   logic             alu_cin;
   logic [3:0]       alu_a;
   logic [3:0]       alu_b;
   logic [3:0]       alu_g;
   logic             alu_cout;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_g;
   logic             rsp_cout;
   logic             rsp_zero;
   logic             rsp_neg;
   logic             rsp_ovf_obs;
`ifdef ALU_SEQ_OVF_EN
   logic             rsp_ovf;
   assign rsp_ovf_obs = rsp_ovf;
`else
   assign rsp_ovf_obs = 1'b0;
`endif

   alu_nibble_sequencer #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_cin   (req_cin),
      .req_a     (req_a),
      .req_b     (req_b),
      .alu_s2    (alu_s2),
      .alu_s1    (alu_s1),
      .alu_s0    (alu_s0),
      .alu_cin   (alu_cin),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_g     (alu_g),
      .alu_cout  (alu_cout),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_g     (rsp_g),
      .rsp_cout  (rsp_cout),
      .rsp_zero  (rsp_zero),
`ifdef ALU_SEQ_OVF_EN
      .rsp_ovf   (rsp_ovf),
`endif
      .rsp_neg   (rsp_neg)
   );

   // 4-bit combinational ALU the sequencer drives
   always_comb begin
      alu_g    = 4'h0;
      alu_cout = 1'b0;
      case ({alu_s2, alu_s1, alu_s0})
         3'b000: {alu_cout, alu_g} = {1'b0, alu_a} + {4'b0, alu_cin};
         3'b001: {alu_cout, alu_g} = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
         3'b010: {alu_cout, alu_g} = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'b0, alu_cin};
         3'b011: {alu_cout, alu_g} = {1'b0, alu_a} + 5'h0F + {4'b0, alu_cin};
         3'b100: alu_g = alu_a & alu_b;
         3'b101: alu_g = alu_a | alu_b;
         3'b110: alu_g = alu_a ^ alu_b;
         default: alu_g = ~alu_a;
      endcase
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [WIDTH-1:0] g;
      logic             cout;
      logic             zero;
      logic             neg;
      logic             ovf;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [2:0] op, input logic cin,
                                  input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      exp_t          e;
      logic [WIDTH:0] s;
      logic [WIDTH-1:0] y;
      case (op[1:0])
         2'b00:   y = '0;
         2'b01:   y = b;
         2'b10:   y = ~b;
         default: y = '1;
      endcase
      e = '0;
      if (!op[2]) begin
         s      = {1'b0, a} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
         e.g    = s[WIDTH-1:0];
         e.cout = s[WIDTH];
      end else begin
         case (op[1:0])
            2'b00:   e.g = a & b;
            2'b01:   e.g = a | b;
            2'b10:   e.g = a ^ b;
            default: e.g = ~a;
         endcase
      end
      e.zero = (e.g == '0);
      e.neg  = e.g[WIDTH-1];
      e.ovf  = !op[2] && (a[WIDTH-1] == y[WIDTH-1]) && (e.g[WIDTH-1] != a[WIDTH-1]);
      return e;
   endfunction

   task automatic accept(input logic [2:0] op, input logic cin,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      int w;
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = op;
      req_cin   = cin;
      req_a     = a;
      req_b     = b;
      w = 0;
      while (!req_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("req_ready_before_accept", 32'(req_ready), 32'd1);
      @(posedge clk);
      sb.push_back(model(op, cin, a, b));
      #1;
      chk("run_alu_a_nib0", 32'(alu_a), 32'(a[3:0]));
      chk("run_alu_cin_nib0", 32'(alu_cin), 32'(cin));
      chk("run_alu_op", 32'({alu_s2, alu_s1, alu_s0}), 32'(op));
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic run_op(input logic [2:0] op, input logic cin,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int hold);
      int   n;
      exp_t e;
      logic [WIDTH-1:0] held;
      accept(op, cin, a, b);
      n = 1;
      @(posedge clk);
      #1;
      while (!rsp_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("latency", 32'(n), 32'd4);
      if (sb.size() == 0) begin
         chk("scoreboard_nonempty", 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      chk("rsp_g", 32'(rsp_g), 32'(e.g));
      chk("rsp_cout", 32'(rsp_cout), 32'(e.cout));
      chk("rsp_zero", 32'(rsp_zero), 32'(e.zero));
      chk("rsp_neg", 32'(rsp_neg), 32'(e.neg));
`ifdef ALU_SEQ_OVF_EN
      chk("rsp_ovf", 32'(rsp_ovf_obs), 32'(e.ovf));
`endif
      chk("done_alu_a_zero", 32'({alu_s2, alu_s1, alu_s0, alu_cin, alu_a, alu_b}), 32'd0);
      held = rsp_g;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         req_valid = 1'b1;
         req_op    = 3'b001;
         req_a     = 16'h1111;
         req_b     = 16'h2222;
         #1;
         chk("bp_rsp_g_stable", 32'(rsp_g), 32'(held));
         chk("bp_req_ready_low", 32'(req_ready), 32'd0);
         chk("bp_rsp_valid_high", 32'(rsp_valid), 32'd1);
      end
      @(negedge clk);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("post_hs_valid_low", 32'(rsp_valid), 32'd0);
      chk("post_hs_ready_high", 32'(req_ready), 32'd1);
      @(negedge clk);
      rsp_ready = 1'b0;
      if (hold > 0) begin
         for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("second_req_not_taken", 32'(rsp_valid), 32'd0);
         end
      end
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      req_op    = 3'b000;
      req_cin   = 1'b0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_req_ready", 32'(req_ready), 32'd1);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_alu_outs", 32'({alu_s2, alu_s1, alu_s0, alu_cin, alu_a, alu_b}), 32'd0);
      chk("reset_rsp_g", 32'(rsp_g), 32'd0);
      chk("reset_rsp_cout", 32'(rsp_cout), 32'd0);
      chk("reset_rsp_ovf", 32'(rsp_ovf_obs), 32'd0);

      run_op(3'b001, 1'b0, 16'h1234, 16'h0FFF, 0);
      run_op(3'b010, 1'b1, 16'h0005, 16'h0007, 0);
      run_op(3'b001, 1'b0, 16'hFFFF, 16'h0001, 0);
      run_op(3'b001, 1'b0, 16'h7FFF, 16'h0001, 0);
      run_op(3'b110, 1'b1, 16'hF0F0, 16'hFF00, 0);
      run_op(3'b111, 1'b1, 16'h00FF, 16'h1234, 0);
      run_op(3'b000, 1'b1, 16'hFFFF, 16'h5555, 0);
      run_op(3'b011, 1'b0, 16'h8000, 16'h0000, 0);
      for (int k = 0; k < 8; k++) begin
         run_op(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                16'($urandom), 16'($urandom), 0);
      end

      run_op(3'b001, 1'b0, 16'hABCD, 16'h1111, 5);

      accept(3'b001, 1'b1, 16'hFFFF, 16'hEEEE);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrun_rst_valid", 32'(rsp_valid), 32'd0);
      chk("midrun_rst_alu_outs", 32'({alu_s2, alu_s1, alu_s0, alu_cin, alu_a, alu_b}), 32'd0);
      chk("midrun_rst_rsp_g", 32'(rsp_g), 32'd0);
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("after_rst_req_ready", 32'(req_ready), 32'd1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("aborted_no_rsp", 32'(rsp_valid), 32'd0);
      end

      run_op(3'b101, 1'b0, 16'hA0A0, 16'h0505, 0);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
